// File: rtl/axi4_csr_master_pkg.sv
// Shared AXI4 types for the CSR initiator: response codes, beat size and FSM states.
package axi4_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } XRESP_t;

  localparam logic [2:0] S4 = 3'b010;

  typedef enum logic [2:0] {
    M_IDLE,
    M_AR,
    M_R,
    M_AWW,
    M_B,
    M_RSP
  } MState_t;

  // A protocol violation downgrades the response to SLVERR but never hides a DECERR.
  function automatic XRESP_t force_err(input XRESP_t r);
    return (r == DECERR) ? DECERR : SLVERR;
  endfunction

endpackage

// File: rtl/axi4_csr_master_if.sv
// AXI4 bus with the subset of fields used by single-beat CSR traffic.
interface axi4 #(
  parameter int unsigned idlen = 4
);
  import axi4_pkg::*;

  logic             aw_valid;
  logic             aw_ready;
  logic [idlen-1:0] aw_id;
  logic [31:0]      aw_addr;
  logic [7:0]       aw_len;
  logic [2:0]       aw_size;
  logic [1:0]       aw_burst;
  logic [2:0]       aw_prot;

  logic             w_valid;
  logic             w_ready;
  logic [31:0]      w_data;
  logic [3:0]       w_strb;
  logic             w_last;

  logic             b_valid;
  logic             b_ready;
  logic [idlen-1:0] b_id;
  XRESP_t           b_resp;

  logic             ar_valid;
  logic             ar_ready;
  logic [idlen-1:0] ar_id;
  logic [31:0]      ar_addr;
  logic [7:0]       ar_len;
  logic [2:0]       ar_size;
  logic [1:0]       ar_burst;
  logic [2:0]       ar_prot;

  logic             r_valid;
  logic             r_ready;
  logic [idlen-1:0] r_id;
  logic [31:0]      r_data;
  XRESP_t           r_resp;
  logic             r_last;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_prot,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_id, b_resp,
    output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_prot,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id, b_resp,
    input  b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last,
    input  r_ready
  );

endinterface

// File: rtl/axi4_csr_master.sv
// Single-outstanding AXI4 initiator: one command in, one single-beat 32-bit
// transaction on the bus, one response out.
module axi4_csr_master
  import axi4_pkg::*;
#(
  parameter int unsigned ID      = 0,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  axi4.master         bus,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output XRESP_t      rsp_resp_o,
  output logic        proto_err_o,
  output logic        timeout_o
);

  localparam int unsigned IDW  = bus.idlen;
  localparam int unsigned CW   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  localparam logic [IDW-1:0] MY_ID = IDW'(ID);

  MState_t       state, state_nx;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  XRESP_t        resp_q;
  logic          aw_done, w_done;
  logic [CW-1:0] cnt;
  logic          proto_err_q, timeout_q;
  logic          r_bad, b_bad, waiting, stay;

  assign r_bad   = (bus.r_id != MY_ID) || !bus.r_last;
  assign b_bad   = (bus.b_id != MY_ID);
  assign waiting = (state == M_AR) || (state == M_R) || (state == M_AWW) || (state == M_B);
  assign stay    = (state_nx == state);

  assign bus.ar_id    = MY_ID;
  assign bus.ar_addr  = addr_q;
  assign bus.ar_len   = '0;
  assign bus.ar_size  = S4;
  assign bus.ar_burst = '0;
  assign bus.ar_prot  = '0;
  assign bus.aw_id    = MY_ID;
  assign bus.aw_addr  = addr_q;
  assign bus.aw_len   = '0;
  assign bus.aw_size  = S4;
  assign bus.aw_burst = '0;
  assign bus.aw_prot  = '0;
  assign bus.w_data   = wdata_q;
  assign bus.w_strb   = 4'hF;
  assign bus.w_last   = 1'b1;

  assign rsp_rdata_o = rdata_q;
  assign rsp_resp_o  = resp_q;
  assign proto_err_o = proto_err_q;
  assign timeout_o   = timeout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= M_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= OKAY;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      cnt         <= '0;
      proto_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == M_IDLE && cmd_valid_i) begin
        we_q    <= cmd_we_i;
        addr_q  <= cmd_addr_i & ~32'h3;
        wdata_q <= cmd_wdata_i;
        rdata_q <= '0;
        resp_q  <= OKAY;
      end
      if (state == M_R && bus.r_valid) begin
        rdata_q <= bus.r_data;
        resp_q  <= r_bad ? force_err(bus.r_resp) : bus.r_resp;
        if (r_bad) proto_err_q <= 1'b1;
      end
      if (state == M_B && bus.b_valid) begin
        resp_q <= b_bad ? force_err(bus.b_resp) : bus.b_resp;
        if (b_bad) proto_err_q <= 1'b1;
      end
      // Handshake flags live only for one AWW visit; each valid drops after its own handshake.
      if (state == M_AWW && stay) begin
        aw_done <= aw_done | bus.aw_ready;
        w_done  <= w_done | bus.w_ready;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (waiting && stay) begin
        if (cnt != TMAX) begin
          cnt <= cnt + 1'b1;
          if (TIMEOUT != 0 && (cnt + 1'b1) == TMAX) timeout_q <= 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nx     = state;
    cmd_ready_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    bus.ar_valid = 1'b0;
    bus.r_ready  = 1'b0;
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
    bus.b_ready  = 1'b0;
    unique case (state)
      M_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_nx = cmd_we_i ? M_AWW : M_AR;
      end
      M_AR: begin
        bus.ar_valid = 1'b1;
        if (bus.ar_ready) state_nx = M_R;
      end
      M_R: begin
        bus.r_ready = 1'b1;
        if (bus.r_valid) state_nx = M_RSP;
      end
      M_AWW: begin
        bus.aw_valid = !aw_done;
        bus.w_valid  = !w_done;
        if ((aw_done || bus.aw_ready) && (w_done || bus.w_ready)) state_nx = M_B;
      end
      M_B: begin
        bus.b_ready = 1'b1;
        if (bus.b_valid) state_nx = M_RSP;
      end
      M_RSP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_nx = M_IDLE;
      end
      default: state_nx = M_IDLE;
    endcase
  end

endmodule

// File: doc/axi4_csr_master.md
# axi4_csr_master

Single-outstanding AXI4 initiator that turns a simple command/response handshake into one-beat, 32-bit CSR reads and writes on an `axi4` master port. It is the initiator counterpart to the team's AXI4 CSR responders, such as the UART register file. It is used by test sequencers, boot loaders and small controllers to program peripherals without a full bus fabric. Each command produces exactly one AXI transaction (len 0, size S4) and exactly one response.

## Interface
Parameters:
- `ID`, 0: AXI ID placed on AR/AW; responses must return it.
- `TIMEOUT`, 1024: cycles to wait for a handshake or response before the timeout flag is raised. Value 0 disables the timeout.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous and active-low; sampled on `posedge clk` only.
- `bus`  master modport  —  `axi4.master` port; ID width `bus.idlen`.
- `cmd_valid_i`  in  1  command valid.
- `cmd_ready_o`  out  1  command accepted when `cmd_valid_i` is also high.
- `cmd_we_i`  in  1  1 = write, 0 = read.
- `cmd_addr_i`  in  32  byte address; bits [1:0] are ignored and forced to 0.
- `cmd_wdata_i`  in  32  write data.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response consumed.
- `rsp_rdata_o`  out  32  read data; 0 for writes.
- `rsp_resp_o`  out  XRESP_t  OKAY, SLVERR or DECERR.
- `proto_err_o`  out  1  sticky flag for an ID mismatch or missing `r.last`.
- `timeout_o`  out  1  sticky timeout flag.

## Operation
- FSM states: M_IDLE, M_AR, M_R, M_AWW, M_B, M_RSP. The FSM resets to M_IDLE.
- **M_IDLE**
  - `cmd_ready_o = 1`.
  - When `cmd_valid_i` is high, latch addr, wdata and we, clear the resp/rdata registers, then go to M_AR if reading, else M_AWW.
- **M_AR**
  - `ar_valid = 1`, `ar.addr` = latched addr, `ar.id = ID`, `ar.len = 0`, `ar.size = S4`.
  - On `ar_ready`, go to M_R.
- **M_R**
  - `r_ready = 1`.
  - On `r_valid`, capture `r.data` and `r.resp`, then go to M_RSP.
- **M_AWW**
  - `aw_valid` and `w_valid` are raised together.
  - `w.data` = latched data, `w.strb = 4'hF`, `w.last = 1`.
  - Internal flags `aw_done` and `w_done` record each handshake. Each valid drops the cycle after its own handshake, in either order or simultaneously.
  - When both flags are set, go to M_B.
- **M_B**
  - `b_ready = 1`.
  - On `b_valid`, capture `b.resp` and go to M_RSP.
- **M_RSP**
  - `rsp_valid_o = 1`. Outputs stay stable until `rsp_ready_i`, then the FSM returns to M_IDLE.
- All AXI channel fields not listed above are driven to `'0`.
- All `*_valid`/`*_ready` outputs are low outside their state.
- **ID or last check:**
  - Applies if `r.id`/`b.id` ≠ ID, or `r.last` = 0 on the captured beat.
  - The response is still consumed.
  - `rsp_resp_o` is forced to SLVERR (unless the slave already returned DECERR).
  - `proto_err_o` is set.
- **Timeout:**
  - A counter runs in M_AR, M_R, M_AWW and M_B, and clears on every state change.
  - Reaching TIMEOUT sets `timeout_o`.
  - The FSM keeps waiting, because AXI cannot abandon a transaction.
  - The counter saturates instead of wrapping.
- Sticky flags clear only on reset.

## Timing
- **Reset values:**
  - All valid/ready outputs are 0.
  - `rsp_rdata_o = 0`, `rsp_resp_o = OKAY`.
  - Both sticky flags are 0.
  - The state is M_IDLE, so `cmd_ready_o = 1` the cycle after reset deasserts.
- All outputs are decoded from registered state and data. No combinational path exists from `bus.*_ready/valid` to `bus.*_valid/ready`.
- **Read latency** against a responder that accepts immediately and responds on the next cycle:
  - Command accepted at cycle 0.
  - `ar_valid` at cycle 1.
  - `r` handshake at cycle 2.
  - `rsp_valid_o` at cycle 3.
- Write latency is identical, with AW+W at cycle 1 and B at cycle 2.
- Back-to-back throughput: the next command is accepted the cycle after `rsp_ready_i`, so one transaction takes at least 4 cycles.
- Valids never drop without a handshake, and latched payloads never change while a valid is asserted.
- Reset mid-transaction:
  - Next edge: every output returns to its reset value and in-flight data is discarded.
  - The system resets the responder together with this block.

## Structure
- The state enum `MState_t` goes in `axi4_pkg`, alongside XRESP_t and S4.
- Timeout width is `$clog2(TIMEOUT+1)`, with a minimum of 1.
- No sub-module: a single FSM file plus the counter.

## Test plan
- **Read:** read 0x0000_0020 from a responder returning 0x0001_0000/OKAY → one AR (len 0, size S4, id ID), then `rsp_rdata_o` = 0x0001_0000, OKAY.
- **Write with AW and W handshaking in different cycles:** write 0x0000_0A2C to 0x00 while the responder accepts W two cycles before AW → one W beat, `strb` F, then `rsp_resp_o` = OKAY.
- **Error responses:**
  - Read 0x0000_0FFC where the responder returns DECERR → DECERR forwarded.
  - Write to a read-only address where the responder returns SLVERR → SLVERR forwarded.
- **Backpressure:** hold `rsp_ready_i` low for 5 cycles → rsp stable, `cmd_ready_o` 0; a command issued during the stall is taken only after release.
- **Protocol error and timeout:**
  - `b.id` = ID+1 → SLVERR and `proto_err_o` 1.
  - Separately, with TIMEOUT = 8 and `ar_ready` stuck at 0 → `timeout_o` 1 at the 8th cycle, `ar_valid` still 1.
- **Reset mid-transaction:** `rst_n` low during M_AWW → next edge all valids 0; after release, a fresh read completes normally.
